// File: rtl/operand_stage.sv
// ============================================================================
//  Module   : operand_stage
//  Purpose  : Two-channel operand collector; per-channel FIFOs, paired fire,
//             registered credit return. Optional macro: OPERAND_BYPASS_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef PATH_WIDTH
`define PATH_WIDTH 8
`endif
`ifndef META_BITS
`define META_BITS 2
`endif

module operand_stage #(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [`PATH_WIDTH:0] in0,
  input  logic [`PATH_WIDTH:0] in1,
  output logic                 credit0,
  output logic                 credit1,
  input  logic                 out_ready,
  output logic [`PATH_WIDTH:0] d_in_c0,
  output logic [`PATH_WIDTH:0] d_in_c1,
  output logic                 fire,
  output logic                 ovf_err
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ent_w = `PATH_WIDTH;

  logic [c_ent_w-1:0] r_mem    [2][DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr [2];
  logic [c_ptr_w-1:0] r_wr_ptr [2];
  logic [c_cnt_w-1:0] r_count  [2];
  logic [1:0]         r_credit;
  logic               r_ovf;

  logic [`PATH_WIDTH:0] w_in   [2];
  logic [c_ent_w-1:0]   w_head [2];
  logic [1:0]           w_byp;
  logic [1:0]           w_avail;
  logic [1:0]           w_full;
  logic [1:0]           w_push;
  logic [1:0]           w_pop;
  logic [1:0]           w_ovf_hit;
  logic                 w_fire;

  assign w_in[0] = in0;
  assign w_in[1] = in1;

  function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      w_byp[ch] = 1'b0;
`ifdef OPERAND_BYPASS_EN
      // An arrival on an empty channel stands in as the head this cycle
      w_byp[ch] = w_in[ch][0] & ~rst & (r_count[ch] == '0);
`endif
      w_avail[ch] = (r_count[ch] != '0) | w_byp[ch];
      w_full[ch]  = (r_count[ch] == c_cnt_w'(DEPTH));
      if (r_count[ch] != '0)
        w_head[ch] = r_mem[ch][r_rd_ptr[ch]];
      else if (w_byp[ch])
        w_head[ch] = w_in[ch][`PATH_WIDTH:1];
      else
        w_head[ch] = '0;
    end
    w_fire = out_ready & w_avail[0] & w_avail[1];
    for (int ch = 0; ch < 2; ch++) begin
      w_pop[ch]     = w_fire & (r_count[ch] != '0);
      // A pop in the same cycle frees the slot, so a full channel still accepts
      w_push[ch]    = w_in[ch][0] & ~(w_fire & w_byp[ch]) & (~w_full[ch] | w_fire);
      w_ovf_hit[ch] = w_in[ch][0] & w_full[ch] & ~w_fire;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        r_rd_ptr[ch] <= '0;
        r_wr_ptr[ch] <= '0;
        r_count[ch]  <= '0;
      end
      r_credit <= '0;
      r_ovf    <= 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (w_push[ch]) begin
          r_mem[ch][r_wr_ptr[ch]] <= w_in[ch][`PATH_WIDTH:1];
          r_wr_ptr[ch]            <= f_inc(r_wr_ptr[ch]);
        end
        if (w_pop[ch])
          r_rd_ptr[ch] <= f_inc(r_rd_ptr[ch]);
        if (w_push[ch] && !w_pop[ch])
          r_count[ch] <= r_count[ch] + 1'b1;
        else if (w_pop[ch] && !w_push[ch])
          r_count[ch] <= r_count[ch] - 1'b1;
      end
      r_credit <= {w_fire, w_fire};
      if (|w_ovf_hit)
        r_ovf <= 1'b1;
    end
  end

  assign fire    = w_fire;
  assign d_in_c0 = {w_head[0], w_fire};
  assign d_in_c1 = {w_head[1], w_fire};
  assign credit0 = r_credit[0];
  assign credit1 = r_credit[1];
  assign ovf_err = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_operand_stage.sv
// ============================================================================
//  Module   : tb_operand_stage
//  Purpose  : Directed bench for operand_stage with a queue-based model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef PATH_WIDTH
`define PATH_WIDTH 8
`endif

module tb_operand_stage;

  localparam int DEPTH = 2;
  localparam int PW    = `PATH_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW:0]   in0 = '0;
  logic [PW:0]   in1 = '0;
  logic          out_ready = 1'b0;
  logic          credit0, credit1, fire, ovf_err;
  logic [PW:0]   d_in_c0, d_in_c1;

  int n_tests = 0;
  int n_fail  = 0;

  operand_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in0(in0), .in1(in1),
    .credit0(credit0), .credit1(credit1), .out_ready(out_ready),
    .d_in_c0(d_in_c0), .d_in_c1(d_in_c1), .fire(fire), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PW:0] pk(input int d, input bit p, input bit v);
    return {d[PW-2:0], p, v};
  endfunction

  // Model: one queue per channel, sticky overflow and pending credits
  logic [PW-1:0] q0[$], q1[$];
  bit m_ovf, m_cr0, m_cr1, armed;

  always @(negedge clk) begin : cmp
    bit b0, b1, a0, a1, f;
    logic [PW-1:0] h0, h1;
    if (rst) begin
      q0.delete(); q1.delete();
      m_ovf = 0; m_cr0 = 0; m_cr1 = 0; armed = 1;
    end else if (armed) begin
      b0 = 0; b1 = 0;
`ifdef OPERAND_BYPASS_EN
      b0 = in0[0] && q0.size() == 0;
      b1 = in1[0] && q1.size() == 0;
`endif
      a0 = q0.size() > 0 || b0;
      a1 = q1.size() > 0 || b1;
      h0 = q0.size() > 0 ? q0[0] : (b0 ? in0[PW:1] : '0);
      h1 = q1.size() > 0 ? q1[0] : (b1 ? in1[PW:1] : '0);
      f  = out_ready && a0 && a1;
      check("m_fire",    32'(fire),    32'(f));
      check("m_d_in_c0", 32'(d_in_c0), 32'({h0, f}));
      check("m_d_in_c1", 32'(d_in_c1), 32'({h1, f}));
      check("m_credit0", 32'(credit0), 32'(m_cr0));
      check("m_credit1", 32'(credit1), 32'(m_cr1));
      check("m_ovf_err", 32'(ovf_err), 32'(m_ovf));
      if (f) begin
        if (!b0) void'(q0.pop_front());
        if (!b1) void'(q1.pop_front());
      end
      if (in0[0] && !(f && b0)) begin
        if (q0.size() < DEPTH) q0.push_back(in0[PW:1]); else m_ovf = 1;
      end
      if (in1[0] && !(f && b1)) begin
        if (q1.size() < DEPTH) q1.push_back(in1[PW:1]); else m_ovf = 1;
      end
      m_cr0 = f;
      m_cr1 = f;
    end
  end

  // Inputs change 2 time units after the edge; literal checks sample 1 unit later
  task automatic drive(input bit v0, input int d0, input bit v1, input int d1, input bit rdy);
    @(posedge clk); #2;
    in0 = v0 ? pk(d0, d0[1], 1'b1) : '0;
    in1 = v1 ? pk(d1, d1[0], 1'b1) : '0;
    out_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; in0 = '0; in1 = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    do_reset();
    repeat (3) drive(0, 0, 0, 0, 1);
    check("idle_fire",   32'(fire),    32'd0);
    check("idle_c0",     32'(d_in_c0), 32'd0);
    check("idle_c1",     32'(d_in_c1), 32'd0);
    check("idle_credit", 32'({credit0, credit1}), 32'd0);
    check("idle_ovf",    32'(ovf_err), 32'd0);

    // Basic pair 5/3
    drive(1, 5, 1, 3, 1);
`ifdef OPERAND_BYPASS_EN
    check("pair_fire_c0", 32'(fire),    32'd1);
    check("pair_d0",      32'(d_in_c0), 32'(pk(5, 0, 1)));
    drive(0, 0, 0, 0, 1);
    check("pair_credit",  32'({credit0, credit1}), 32'b11);
`else
    check("pair_nofire_c0", 32'(fire), 32'd0);
    drive(0, 0, 0, 0, 1);
    check("pair_fire_c1", 32'(fire),    32'd1);
    check("pair_d0",      32'(d_in_c0), 32'(pk(5, 0, 1)));
    check("pair_d1",      32'(d_in_c1), 32'(pk(3, 1, 1)));
    drive(0, 0, 0, 0, 1);
    check("pair_credit",  32'({credit0, credit1}), 32'b11);
`endif

    // Overflow on channel 0, then one pairing
    do_reset();
    drive(1, 10, 0, 0, 1);
    drive(1, 11, 0, 0, 1);
    drive(1, 12, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    check("ovf_set",    32'(ovf_err), 32'd1);
    check("ovf_nofire", 32'(fire),    32'd0);
    drive(0, 0, 1, 20, 1);
`ifndef OPERAND_BYPASS_EN
    drive(0, 0, 0, 0, 1);
`endif
    check("ovf_pair_fire", 32'(fire),    32'd1);
    check("ovf_pair_d0",   32'(d_in_c0), 32'(pk(10, 1, 1)));
    drive(0, 0, 0, 0, 1);
    check("ovf_one_fire",  32'(fire),    32'd0);
    check("ovf_sticky",    32'(ovf_err), 32'd1);

    // Backpressure with both FIFOs full
    do_reset();
    drive(1, 30, 1, 40, 0);
    drive(1, 31, 1, 41, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    check("bp_nofire",  32'(fire), 32'd0);
    check("bp_nocred",  32'({credit0, credit1}), 32'd0);
    drive(0, 0, 0, 0, 1);
    check("bp_fire1",   32'(d_in_c0), 32'(pk(30, 1, 1)));
    drive(0, 0, 0, 0, 1);
    check("bp_fire2",   32'(d_in_c0), 32'(pk(31, 1, 1)));
    drive(0, 0, 0, 0, 0);
    check("bp_credit",  32'(credit1), 32'd1);

    // Full FIFO with push and fire in the same cycle
    do_reset();
    drive(1, 50, 1, 60, 0);
    drive(1, 51, 1, 61, 0);
    drive(1, 52, 1, 62, 1);
    check("pf_fire",    32'(d_in_c0), 32'(pk(50, 1, 1)));
    drive(0, 0, 0, 0, 1);
    check("pf_ovf",     32'(ovf_err), 32'd0);
    check("pf_second",  32'(d_in_c0), 32'(pk(51, 1, 1)));
    drive(0, 0, 0, 0, 1);
    check("pf_new_c0",  32'(d_in_c0), 32'(pk(52, 0, 1)));
    check("pf_new_c1",  32'(d_in_c1), 32'(pk(62, 0, 1)));
    drive(0, 0, 0, 0, 0);

    // Sustained streaming
    do_reset();
    for (int i = 0; i < 12; i++) drive(1, 70 + i, 1, 90 + i, 1);
    repeat (3) drive(0, 0, 0, 0, 1);

    // Channel 1 waiting, channel 0 arrives in cycle 4
    do_reset();
    drive(0, 0, 1, 7, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(1, 2, 0, 0, 1);
`ifdef OPERAND_BYPASS_EN
    check("byp_fire", 32'(fire),    32'd1);
    check("byp_c0",   32'(d_in_c0), 32'(pk(2, 1, 1)));
    check("byp_c1",   32'(d_in_c1), 32'(pk(7, 1, 1)));
    drive(0, 0, 0, 0, 1);
    check("byp_credit0", 32'(credit0), 32'd1);
`else
    check("nobyp_wait", 32'(fire), 32'd0);
    drive(0, 0, 0, 0, 1);
    check("nobyp_fire", 32'(fire),    32'd1);
    check("nobyp_c1",   32'(d_in_c1), 32'(pk(7, 1, 1)));
`endif
    repeat (2) drive(0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
